// File: rtl/ctr_rx_tracker.sv
// ctr_rx_tracker: receive-side CTR counter tracker for the decryptor path.
// Checks each received 128-bit counter against the locally expected value,
// forwards accepted counters to the keystream core through a single-entry
// output register, and rejects replayed or far-jumped blocks. ERR_LIMIT
// consecutive rejections drop the tracker back to UNSYNC.
// Optional feature macro: CTR_RX_STATS_EN (saturating accept/drop counters).
module ctr_rx_tracker #(
  parameter int MAX_GAP   = 16,
  parameter int ERR_LIMIT = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         ctr_valid_i,
  output logic         ctr_ready_o,
  input  logic [127:0] ctr_i,
  output logic         ks_valid_o,
  input  logic         ks_ready_i,
  output logic [127:0] ks_ctr_o,
  output logic         synced_o,
  output logic [127:0] expected_o,
  output logic         gap_o,
  output logic         replay_o,
  output logic         jump_o,
  output logic [31:0]  accept_cnt_o,
  output logic [31:0]  drop_cnt_o
);

  typedef enum logic {UNSYNC = 1'b0, TRACK = 1'b1} state_t;

  localparam logic [127:0] MAX_GAP_W     = 128'(MAX_GAP);
  localparam logic [3:0]   ERR_LAST_W    = 4'(ERR_LIMIT - 1);

  state_t        state_reg,    state_next;
  logic [127:0]  exp_reg,      exp_next;
  logic [3:0]    err_reg,      err_next;
  logic          ks_valid_reg, ks_valid_next;
  logic [127:0]  ks_ctr_reg,   ks_ctr_next;
  logic          gap_reg,      gap_next;
  logic          replay_reg,   replay_next;
  logic          jump_reg,     jump_next;
  logic          accept_evt;
  logic          reject_evt;

  logic          xfer;
  logic [127:0]  diff;
  logic          in_window;

  // Pass-through ready: the output slot frees up on the same edge it drains.
  assign ctr_ready_o = !ks_valid_reg || ks_ready_i;
  assign xfer        = ctr_valid_i && ctr_ready_o;

  // Modulo-2^128 distance from expected; a set MSB means "behind expected".
  assign diff      = ctr_i - exp_reg;
  assign in_window = (diff <= MAX_GAP_W);

  // Next-state decision for one received counter, with clr_i taking priority.
  always_comb begin
    state_next    = state_reg;
    exp_next      = exp_reg;
    err_next      = err_reg;
    ks_valid_next = ks_valid_reg && !ks_ready_i;
    ks_ctr_next   = ks_ctr_reg;
    gap_next      = 1'b0;
    replay_next   = 1'b0;
    jump_next     = 1'b0;
    accept_evt    = 1'b0;
    reject_evt    = 1'b0;

    if (clr_i) begin
      state_next    = UNSYNC;
      exp_next      = '0;
      err_next      = '0;
      ks_valid_next = 1'b0;
      ks_ctr_next   = '0;
    end else if (xfer) begin
      if (state_reg == UNSYNC || in_window) begin
        accept_evt    = 1'b1;
        gap_next      = (state_reg == TRACK) && (diff != '0);
        state_next    = TRACK;
        exp_next      = ctr_i + 128'd1;
        err_next      = '0;
        ks_valid_next = 1'b1;
        ks_ctr_next   = ctr_i;
      end else begin
        reject_evt  = 1'b1;
        replay_next = diff[127];
        jump_next   = !diff[127];
        if (err_reg == ERR_LAST_W) begin
          state_next = UNSYNC;
          err_next   = '0;
        end else begin
          err_next = err_reg + 4'd1;
        end
      end
    end
  end

  // Tracker state, output register and event pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= UNSYNC;
      exp_reg      <= '0;
      err_reg      <= '0;
      ks_valid_reg <= 1'b0;
      ks_ctr_reg   <= '0;
      gap_reg      <= 1'b0;
      replay_reg   <= 1'b0;
      jump_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      exp_reg      <= exp_next;
      err_reg      <= err_next;
      ks_valid_reg <= ks_valid_next;
      ks_ctr_reg   <= ks_ctr_next;
      gap_reg      <= gap_next;
      replay_reg   <= replay_next;
      jump_reg     <= jump_next;
    end
  end

  assign ks_valid_o = ks_valid_reg;
  assign ks_ctr_o   = ks_ctr_reg;
  assign synced_o   = (state_reg == TRACK);
  assign expected_o = exp_reg;
  assign gap_o      = gap_reg;
  assign replay_o   = replay_reg;
  assign jump_o     = jump_reg;

`ifdef CTR_RX_STATS_EN
  logic [31:0] acc_cnt_reg;
  logic [31:0] drop_cnt_reg;

  // Saturating accept/drop statistics, cleared together with the tracker.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_cnt_reg  <= '0;
      drop_cnt_reg <= '0;
    end else if (clr_i) begin
      acc_cnt_reg  <= '0;
      drop_cnt_reg <= '0;
    end else begin
      if (accept_evt && (acc_cnt_reg != 32'hFFFF_FFFF)) begin
        acc_cnt_reg <= acc_cnt_reg + 32'd1;
      end
      if (reject_evt && (drop_cnt_reg != 32'hFFFF_FFFF)) begin
        drop_cnt_reg <= drop_cnt_reg + 32'd1;
      end
    end
  end

  assign accept_cnt_o = acc_cnt_reg;
  assign drop_cnt_o   = drop_cnt_reg;
`else
  logic unused_evt;
  assign unused_evt   = accept_evt ^ reject_evt;
  assign accept_cnt_o = '0;
  assign drop_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_ctr_rx_tracker.sv
// Testbench for ctr_rx_tracker: directed walk through the main scenarios,
// then randomized traffic checked against a transaction-level model.
module tb_ctr_rx_tracker;

  localparam int MAX_GAP   = 16;
  localparam int ERR_LIMIT = 4;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         clr_i = 1'b0;
  logic         ctr_valid_i = 1'b0;
  logic         ctr_ready_o;
  logic [127:0] ctr_i = '0;
  logic         ks_valid_o;
  logic         ks_ready_i = 1'b1;
  logic [127:0] ks_ctr_o;
  logic         synced_o;
  logic [127:0] expected_o;
  logic         gap_o;
  logic         replay_o;
  logic         jump_o;
  logic [31:0]  accept_cnt_o;
  logic [31:0]  drop_cnt_o;

  ctr_rx_tracker #(.MAX_GAP(MAX_GAP), .ERR_LIMIT(ERR_LIMIT)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clr_i        (clr_i),
    .ctr_valid_i  (ctr_valid_i),
    .ctr_ready_o  (ctr_ready_o),
    .ctr_i        (ctr_i),
    .ks_valid_o   (ks_valid_o),
    .ks_ready_i   (ks_ready_i),
    .ks_ctr_o     (ks_ctr_o),
    .synced_o     (synced_o),
    .expected_o   (expected_o),
    .gap_o        (gap_o),
    .replay_o     (replay_o),
    .jump_o       (jump_o),
    .accept_cnt_o (accept_cnt_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: expected counter, sync flag, rejection run length,
  // held output counter and statistics.
  logic [127:0] m_exp;
  bit           m_sync;
  int           m_err;
  bit           m_ksv;
  logic [127:0] m_ksc;
  bit           m_gap, m_rep, m_jmp;
  longint       m_acc, m_drop;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_exp = '0; m_sync = 0; m_err = 0; m_ksv = 0; m_ksc = '0;
    m_gap = 0; m_rep = 0; m_jmp = 0; m_acc = 0; m_drop = 0;
  endtask

  // One clock edge of the model given the inputs presented before that edge.
  task automatic model_step(input bit v, input logic [127:0] c, input bit kr, input bit clr);
    logic [127:0] d;
    bit take, acc;
    m_gap = 0; m_rep = 0; m_jmp = 0;
    if (clr) begin
      model_reset();
      return;
    end
    take = v && (!m_ksv || kr);
    if (kr) m_ksv = 0;
    if (!take) return;
    d = c - m_exp;
    acc = !m_sync || (d <= 128'(MAX_GAP));
    if (acc) begin
      m_gap  = m_sync && (d != 0);
      m_sync = 1; m_exp = c + 1; m_err = 0; m_ksv = 1; m_ksc = c;
      if (m_acc < 64'hFFFF_FFFF) m_acc++;
    end else begin
      if (d >= {1'b1, 127'b0}) m_rep = 1; else m_jmp = 1;
      m_err++;
      if (m_err == ERR_LIMIT) begin m_sync = 0; m_err = 0; end
      if (m_drop < 64'hFFFF_FFFF) m_drop++;
    end
  endtask

  task automatic check_all(input string pfx);
    chk({pfx, ".ks_valid"}, 128'(ks_valid_o), 128'(m_ksv));
    chk({pfx, ".ks_ctr"},   ks_ctr_o, m_ksc);
    chk({pfx, ".synced"},   128'(synced_o), 128'(m_sync));
    chk({pfx, ".expected"}, expected_o, m_exp);
    chk({pfx, ".gap"},      128'(gap_o), 128'(m_gap));
    chk({pfx, ".replay"},   128'(replay_o), 128'(m_rep));
    chk({pfx, ".jump"},     128'(jump_o), 128'(m_jmp));
`ifdef CTR_RX_STATS_EN
    chk({pfx, ".acc_cnt"},  128'(accept_cnt_o), 128'(m_acc));
    chk({pfx, ".drop_cnt"}, 128'(drop_cnt_o), 128'(m_drop));
`else
    chk({pfx, ".acc_cnt"},  128'(accept_cnt_o), 128'd0);
    chk({pfx, ".drop_cnt"}, 128'(drop_cnt_o), 128'd0);
`endif
  endtask

  // Drive one cycle (called 1 time unit after a rising edge), then check.
  task automatic cycle(input string pfx, input bit v, input logic [127:0] c,
                       input bit kr, input bit clr);
    ctr_valid_i = v; ctr_i = c; ks_ready_i = kr; clr_i = clr;
    #1;
    chk({pfx, ".ready"}, 128'(ctr_ready_o), 128'(!m_ksv || kr));
    @(posedge clk_i);
    model_step(v, c, kr, clr);
    #1;
    check_all(pfx);
    ctr_valid_i = 0; clr_i = 0;
  endtask

  function automatic logic [127:0] pick_ctr(input logic [127:0] e);
    int sel;
    sel = $urandom_range(0, 11);
    case (sel)
      0, 1, 2: return e;
      3, 4:    return e + 128'($urandom_range(1, MAX_GAP));
      5:       return e + 128'(MAX_GAP);
      6:       return e + 128'(MAX_GAP + 1);
      7:       return e + 128'($urandom_range(MAX_GAP + 2, 100000));
      8, 9:    return e - 128'($urandom_range(1, 8));
      10:      return '1;
      default: return {$urandom, $urandom, $urandom, $urandom};
    endcase
  endfunction

  initial begin
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i); #1;

    chk("rst.ready",    128'(ctr_ready_o), 128'd1);
    chk("rst.ks_valid", 128'(ks_valid_o), 128'd0);
    chk("rst.synced",   128'(synced_o), 128'd0);
    chk("rst.expected", expected_o, 128'd0);
    chk("rst.acc_cnt",  128'(accept_cnt_o), 128'd0);
    chk("rst.drop_cnt", 128'(drop_cnt_o), 128'd0);

    cycle("first", 1, 128'h1000, 1, 0);
    chk("first.ks_ctr_c",   ks_ctr_o, 128'h1000);
    chk("first.synced_c",   128'(synced_o), 128'd1);
    chk("first.expected_c", expected_o, 128'h1001);
    cycle("seq1", 1, 128'h1001, 1, 0);
    cycle("seq2", 1, 128'h1002, 1, 0);
    chk("seq2.gap_c", 128'(gap_o), 128'd0);
    cycle("skip", 1, 128'h1005, 1, 0);
    chk("skip.gap_c",      128'(gap_o), 128'd1);
    chk("skip.expected_c", expected_o, 128'h1006);

    cycle("replay", 1, 128'h1003, 1, 0);
    chk("replay.pulse_c",    128'(replay_o), 128'd1);
    chk("replay.ks_valid_c", 128'(ks_valid_o), 128'd0);
    chk("replay.expected_c", expected_o, 128'h1006);
    cycle("jump", 1, 128'h1006 + 128'd17, 1, 0);
    chk("jump.pulse_c",    128'(jump_o), 128'd1);
    chk("jump.ks_valid_c", 128'(ks_valid_o), 128'd0);
    chk("jump.expected_c", expected_o, 128'h1006);
    cycle("rej3", 1, 128'h1000, 1, 0);
    chk("rej3.synced_c", 128'(synced_o), 128'd1);
    cycle("rej4", 1, 128'h2000, 1, 0);
    chk("rej4.synced_c", 128'(synced_o), 128'd0);
    cycle("resync", 1, 128'h9000, 1, 0);
    chk("resync.expected_c", expected_o, 128'h9001);
    chk("resync.synced_c",   128'(synced_o), 128'd1);

    cycle("clr", 1, 128'h9001, 1, 1);
    chk("clr.synced_c",   128'(synced_o), 128'd0);
    chk("clr.expected_c", expected_o, 128'd0);
    cycle("wrap1", 1, '1, 1, 0);
    chk("wrap1.expected_c", expected_o, 128'd0);
    cycle("wrap0", 1, 128'd0, 1, 0);
    chk("wrap0.ks_valid_c", 128'(ks_valid_o), 128'd1);
    chk("wrap0.gap_c",      128'(gap_o), 128'd0);
    chk("wrap0.expected_c", expected_o, 128'd1);

    cycle("stall1", 1, 128'd5, 0, 0);
    chk("stall1.ready_c",  128'(ctr_ready_o), 128'd0);
    chk("stall1.ks_ctr_c", ks_ctr_o, 128'd0);
    cycle("stall2", 1, 128'd1, 0, 0);
    chk("stall2.ks_ctr_c", ks_ctr_o, 128'd0);
    chk("stall2.expected_c", expected_o, 128'd1);

    // Asynchronous reset mid-stall, sampled before the next clock edge.
    #2 rst_ni = 1'b0;
    #1;
    chk("arst.ready",    128'(ctr_ready_o), 128'd1);
    chk("arst.ks_valid", 128'(ks_valid_o), 128'd0);
    chk("arst.ks_ctr",   ks_ctr_o, 128'd0);
    chk("arst.synced",   128'(synced_o), 128'd0);
    chk("arst.expected", expected_o, 128'd0);
    chk("arst.acc_cnt",  128'(accept_cnt_o), 128'd0);
    chk("arst.drop_cnt", 128'(drop_cnt_o), 128'd0);
    model_reset();
    ctr_valid_i = 0; ks_ready_i = 1;
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < 3000; i++) begin
      cycle("rnd", ($urandom_range(0, 3) != 0), pick_ctr(m_exp),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 63) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
